// File: rtl/sm_ram_arbiter_if.sv
// Bundle for the two-requester data-RAM arbiter: both requester
// ports, the shared RAM port and the debug conflict counter.
interface sm_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [CNT_WIDTH-1:0]  conflicts;

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rvalid1, rdata1,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata,
    input  conflicts
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rvalid1, rdata1,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata,
    output conflicts
  );
endinterface

// File: rtl/sm_ram_arbiter.sv
// Two-way arbiter for one port of the synchronous data RAM
// (CPU path on port 0, debug/loader on port 1).
module sm_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_WIDTH  = 16
) (
  input logic             clk,
  input logic             rst,
  sm_ram_arbiter_if.slave bus
);

  logic                  both;
  logic                  gnt0;
  logic                  gnt1;
  logic                  ack0;
  logic                  ack1;

  logic                  last_grant_q;
  logic                  last_grant_d;
  logic                  p1_pend_q;
  logic                  p1_pend_d;
  logic                  p1_own_q;
  logic                  p1_own_d;
  logic                  p2_pend_q;
  logic                  p2_pend_d;
  logic                  p2_own_q;
  logic                  p2_own_d;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [DATA_WIDTH-1:0] rdata1_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

  // Winner for this cycle; on a tie round-robin favours the port
  // that was not served last.
  always_comb begin
    both = bus.req0 & bus.req1;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (both) begin
      if (FIXED_PRIO != 0 || last_grant_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = bus.req0;
      gnt1 = bus.req1;
    end
  end

  // Acks and RAM command; port 0 fields sit on the bus when idle.
  always_comb begin
    ack0          = gnt0 & ~rst;
    ack1          = gnt1 & ~rst;
    bus.ack0      = ack0;
    bus.ack1      = ack1;
    bus.ram_addr  = gnt1 ? bus.addr1 : bus.addr0;
    bus.ram_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    bus.ram_we    = (ack0 & bus.we0) | (ack1 & bus.we1);
  end

  // Next state: grant history, two-stage read pipe, read data
  // capture and the saturating tie counter.
  always_comb begin
    last_grant_d = last_grant_q;
    if (ack0 | ack1) begin
      last_grant_d = ack1;
    end
    p1_pend_d = (ack0 & ~bus.we0) | (ack1 & ~bus.we1);
    p1_own_d  = ack1;
    p2_pend_d = p1_pend_q;
    p2_own_d  = p1_own_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (p1_pend_q & ~p1_own_q) begin
      rdata0_d = bus.ram_rdata;
    end
    if (p1_pend_q & p1_own_q) begin
      rdata1_d = bus.ram_rdata;
    end
    cnt_d = cnt_q;
    if (both && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      p1_pend_q    <= 1'b0;
      p1_own_q     <= 1'b0;
      p2_pend_q    <= 1'b0;
      p2_own_q     <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      p1_pend_q    <= p1_pend_d;
      p1_own_q     <= p1_own_d;
      p2_pend_q    <= p2_pend_d;
      p2_own_q     <= p2_own_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.rvalid0   = p2_pend_q & ~p2_own_q;
  assign bus.rvalid1   = p2_pend_q & p2_own_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.conflicts = cnt_q;

endmodule

// File: tb/tb_sm_ram_arbiter.sv
// Bench for sm_ram_arbiter: round-robin (16-bit counter) and
// fixed-priority (4-bit counter) builds against a queue model.
module tb_sm_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  sm_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) bus_rr ();
  sm_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) bus_fp ();

  sm_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0), .CNT_WIDTH(16)
  ) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr)
  );

  sm_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1), .CNT_WIDTH(4)
  ) u_fp (
    .clk(clk), .rst(rst), .bus(bus_fp)
  );

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];

  logic          ack   [2][2];
  logic          rv    [2][2];
  logic [DW-1:0] rd    [2][2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rwd   [2];
  logic          rwe   [2];
  logic [15:0]   cnt   [2];

  assign bus_rr.req0   = req[0][0];
  assign bus_rr.we0    = we[0][0];
  assign bus_rr.addr0  = addr[0][0];
  assign bus_rr.wdata0 = wdata[0][0];
  assign bus_rr.req1   = req[0][1];
  assign bus_rr.we1    = we[0][1];
  assign bus_rr.addr1  = addr[0][1];
  assign bus_rr.wdata1 = wdata[0][1];
  assign bus_fp.req0   = req[1][0];
  assign bus_fp.we0    = we[1][0];
  assign bus_fp.addr0  = addr[1][0];
  assign bus_fp.wdata0 = wdata[1][0];
  assign bus_fp.req1   = req[1][1];
  assign bus_fp.we1    = we[1][1];
  assign bus_fp.addr1  = addr[1][1];
  assign bus_fp.wdata1 = wdata[1][1];

  assign ack[0][0] = bus_rr.ack0;
  assign ack[0][1] = bus_rr.ack1;
  assign rv[0][0]  = bus_rr.rvalid0;
  assign rv[0][1]  = bus_rr.rvalid1;
  assign rd[0][0]  = bus_rr.rdata0;
  assign rd[0][1]  = bus_rr.rdata1;
  assign raddr[0]  = bus_rr.ram_addr;
  assign rwd[0]    = bus_rr.ram_wdata;
  assign rwe[0]    = bus_rr.ram_we;
  assign cnt[0]    = bus_rr.conflicts;
  assign ack[1][0] = bus_fp.ack0;
  assign ack[1][1] = bus_fp.ack1;
  assign rv[1][0]  = bus_fp.rvalid0;
  assign rv[1][1]  = bus_fp.rvalid1;
  assign rd[1][0]  = bus_fp.rdata0;
  assign rd[1][1]  = bus_fp.rdata1;
  assign raddr[1]  = bus_fp.ram_addr;
  assign rwd[1]    = bus_fp.ram_wdata;
  assign rwe[1]    = bus_fp.ram_we;
  assign cnt[1]    = 16'(bus_fp.conflicts);

  // Synchronous RAMs, one per build, registered read data.
  logic [DW-1:0] ram [2][16];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) begin
        ram[0][i] <= 32'hA000_0000 + 32'(i);
        ram[1][i] <= 32'hA000_0000 + 32'(i);
      end
    end else begin
      if (bus_rr.ram_we) ram[0][bus_rr.ram_addr] <= bus_rr.ram_wdata;
      if (bus_fp.ram_we) ram[1][bus_fp.ram_addr] <= bus_fp.ram_wdata;
    end
    bus_rr.ram_rdata <= ram[0][bus_rr.ram_addr];
    bus_fp.ram_rdata <= ram[1][bus_fp.ram_addr];
  end

  typedef struct {
    int            k;
    int            due;
    int            own;
    logic [DW-1:0] d;
  } ret_t;

  ret_t          rq [$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_m [2][16];
  logic [DW-1:0] m_rd [2][2];
  bit            m_lg [2];
  int            m_cnt [2];
  bit            erv [2][2];
  bit            ackseen [2][2];

  task automatic chk(input int k, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d cyc=%0d got %0h want %0h",
               nm, k, cyc, act, exp);
    end
  endtask

  task automatic step(input int k);
    int   g;
    int   a;
    int   maxc;
    bit   both;
    ret_t e;
    maxc = (k == 0) ? 65535 : 15;
    if (rst) begin
      m_lg[k]    = 1'b1;
      m_cnt[k]   = 0;
      m_rd[k][0] = '0;
      m_rd[k][1] = '0;
      chk(k, "rst_ack0", 64'(ack[k][0]), 64'd0);
      chk(k, "rst_ack1", 64'(ack[k][1]), 64'd0);
      chk(k, "rst_we", 64'(rwe[k]), 64'd0);
      chk(k, "rst_rv0", 64'(rv[k][0]), 64'd0);
      chk(k, "rst_rv1", 64'(rv[k][1]), 64'd0);
      chk(k, "rst_rd0", 64'(rd[k][0]), 64'd0);
      chk(k, "rst_rd1", 64'(rd[k][1]), 64'd0);
      chk(k, "rst_cnt", 64'(cnt[k]), 64'd0);
    end else begin
      both = req[k][0] && req[k][1];
      g = -1;
      if (both) g = (k == 1 || m_lg[k]) ? 0 : 1;
      else if (req[k][0]) g = 0;
      else if (req[k][1]) g = 1;
      a = (g == 1) ? 1 : 0;
      chk(k, "ack0", 64'(ack[k][0]), 64'(g == 0));
      chk(k, "ack1", 64'(ack[k][1]), 64'(g == 1));
      chk(k, "ram_addr", 64'(raddr[k]), 64'(addr[k][a]));
      chk(k, "ram_wdata", 64'(rwd[k]), 64'(wdata[k][a]));
      chk(k, "ram_we", 64'(rwe[k]), 64'(g >= 0 && we[k][a]));
      for (int p = 0; p < 2; p++) begin
        chk(k, "rvalid", 64'(rv[k][p]), 64'(erv[k][p]));
        chk(k, "rdata", 64'(rd[k][p]), 64'(m_rd[k][p]));
      end
      chk(k, "conflicts", 64'(cnt[k]), 64'(m_cnt[k]));
      if (both && m_cnt[k] < maxc) m_cnt[k]++;
      if (g >= 0) begin
        m_lg[k] = (g == 1);
        if (we[k][g]) begin
          mem_m[k][addr[k][g]] = wdata[k][g];
        end else begin
          e.k   = k;
          e.due = cyc + 2;
          e.own = g;
          e.d   = mem_m[k][addr[k][g]];
          rq.push_back(e);
        end
      end
    end
  endtask

  // Reference model and per-cycle compare for both builds.
  always @(negedge clk) begin
    ret_t e;
    cyc++;
    if (ram_init) begin
      for (int i = 0; i < 16; i++) begin
        mem_m[0][i] = 32'hA000_0000 + 32'(i);
        mem_m[1][i] = 32'hA000_0000 + 32'(i);
      end
    end
    for (int k = 0; k < 2; k++) begin
      erv[k][0] = 1'b0;
      erv[k][1] = 1'b0;
    end
    if (rst) begin
      rq.delete();
    end else begin
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        e = rq.pop_front();
        if (e.due == cyc) begin
          erv[e.k][e.own]  = 1'b1;
          m_rd[e.k][e.own] = e.d;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(k);
      ackseen[k][0] = ack[k][0];
      ackseen[k][1] = ack[k][1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic setp(input int k, input int p, input logic r,
                      input logic w, input int a, input logic [DW-1:0] d);
    req[k][p]   = r;
    we[k][p]    = w;
    addr[k][p]  = AW'(a);
    wdata[k][p] = d;
  endtask

  task automatic drive_rand(input int k, input int p);
    if (!req[k][p] || ackseen[k][p]) begin
      req[k][p]   = ($urandom_range(0, 9) < 7);
      we[k][p]    = ($urandom_range(0, 2) == 0);
      addr[k][p]  = AW'($urandom_range(0, 15));
      wdata[k][p] = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      req[k][p] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      setp(k, 0, 0, 0, 0, '0);
      setp(k, 1, 0, 0, 0, '0);
    end
    repeat (2) @(posedge clk);
    look();
    for (int k = 0; k < 2; k++) begin
      chk(k, "init_ack0", 64'(ack[k][0]), 64'd0);
      chk(k, "init_cnt", 64'(cnt[k]), 64'd0);
    end
    tick();
    rst = 1'b0;
    ram_init = 1'b0;
    look();
    for (int k = 0; k < 2; k++) begin
      chk(k, "idle_we", 64'(rwe[k]), 64'd0);
      chk(k, "idle_rv0", 64'(rv[k][0]), 64'd0);
      chk(k, "idle_rd0", 64'(rd[k][0]), 64'd0);
    end

    tick();
    for (int k = 0; k < 2; k++) setp(k, 0, 1, 1, 3, 32'hDEADBEEF);
    look();
    for (int k = 0; k < 2; k++) begin
      chk(k, "wr_ack0", 64'(ack[k][0]), 64'd1);
      chk(k, "wr_we", 64'(rwe[k]), 64'd1);
    end
    tick();
    for (int k = 0; k < 2; k++) setp(k, 0, 1, 0, 3, '0);
    look();
    for (int k = 0; k < 2; k++) chk(k, "rd_ack0", 64'(ack[k][0]), 64'd1);
    tick();
    for (int k = 0; k < 2; k++) req[k][0] = 1'b0;
    look();
    for (int k = 0; k < 2; k++) chk(k, "rd_t1", 64'(rv[k][0]), 64'd0);
    look();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rd_t2_rv0", 64'(rv[k][0]), 64'd1);
      chk(k, "rd_t2_data", 64'(rd[k][0]), 64'hDEADBEEF);
      chk(k, "rd_t2_rv1", 64'(rv[k][1]), 64'd0);
    end

    tick();
    for (int k = 0; k < 2; k++) setp(k, 1, 1, 1, 5, 32'h55);
    look();
    for (int k = 0; k < 2; k++) chk(k, "p1_wr_ack1", 64'(ack[k][1]), 64'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      setp(k, 0, 1, 0, 1, '0);
      setp(k, 1, 1, 0, 2, '0);
    end
    for (int i = 0; i < 4; i++) begin
      look();
      chk(0, "rr_ack0", 64'(ack[0][0]), 64'(i % 2 == 0));
      chk(0, "rr_ack1", 64'(ack[0][1]), 64'(i % 2 == 1));
      chk(1, "fp_ack0", 64'(ack[1][0]), 64'd1);
      chk(1, "fp_ack1", 64'(ack[1][1]), 64'd0);
      if (i == 2) begin
        chk(0, "rr_rv0", 64'(rv[0][0]), 64'd1);
        chk(0, "rr_rd0", 64'(rd[0][0]), 64'hA0000001);
      end
      if (i == 3) begin
        chk(0, "rr_rv1", 64'(rv[0][1]), 64'd1);
        chk(0, "rr_rd1", 64'(rd[0][1]), 64'hA0000002);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) req[k][0] = 1'b0;
    look();
    for (int k = 0; k < 2; k++) begin
      chk(k, "drop_ack1", 64'(ack[k][1]), 64'd1);
      chk(k, "cnt4", 64'(cnt[k]), 64'd4);
    end
    tick();
    for (int k = 0; k < 2; k++) req[k][1] = 1'b0;

    tick();
    for (int k = 0; k < 2; k++) setp(k, 0, 1, 0, 3, '0);
    look();
    for (int k = 0; k < 2; k++) chk(k, "pre_rst_ack0", 64'(ack[k][0]), 64'd1);
    tick();
    for (int k = 0; k < 2; k++) req[k][0] = 1'b0;
    #2 rst = 1'b1;
    look();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      look();
      for (int k = 0; k < 2; k++) chk(k, "rst_drop_rv0", 64'(rv[k][0]), 64'd0);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      setp(k, 0, 1, 0, 4, '0);
      setp(k, 1, 1, 0, 6, '0);
    end
    look();
    chk(0, "post_rst_ack0", 64'(ack[0][0]), 64'd1);
    chk(0, "post_rst_ack1", 64'(ack[0][1]), 64'd0);
    repeat (21) look();
    chk(0, "cnt_21", 64'(cnt[0]), 64'd21);
    chk(1, "cnt_sat", 64'(cnt[1]), 64'hF);
    tick();
    for (int k = 0; k < 2; k++) begin
      req[k][0] = 1'b0;
      req[k][1] = 1'b0;
    end

    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        drive_rand(k, 0);
        drive_rand(k, 1);
      end
      if (n == 1000 || n == 2200) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #4 rst = 1'b0;
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      req[k][0] = 1'b0;
      req[k][1] = 1'b0;
    end
    repeat (4) look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
